// File: rtl/mem_access_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_access_if : control-side request bus and memory-side handshake bus  |
// | Revision      : 1.0                                                     |
// +-------------------------------------------------------------------------+
interface mem_access_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              start;
    logic              write;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_din;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;

    // The sequencer itself
    modport slave (
        input  addr_in, wdata_in, start, write, mem_ack, mem_din,
        output mem_req, mem_we, mem_addr, mem_dout, rdata, busy, done, err
    );

    // Control unit plus memory model driving the sequencer
    modport master (
        output addr_in, wdata_in, start, write, mem_ack, mem_din,
        input  mem_req, mem_we, mem_addr, mem_dout, rdata, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_access_ctrl : DLX data-memory sequencer, 4-phase req/ack handshake  |
// |                   with read-data capture and REQ-phase timeout          |
// | Revision        : 1.0                                                   |
// +-------------------------------------------------------------------------+
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mem_access_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] c_last_count = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_count;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_dout;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= 8'd0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dout <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mem_addr <= bus.addr_in;
                        r_mem_dout <= bus.wdata_in;
                        r_mem_we   <= bus.write;
                        r_err      <= 1'b0;
                        r_count    <= 8'd0;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Ack takes priority over an expiring timeout
                    if (bus.mem_ack) begin
                        if (!r_mem_we) begin
                            r_rdata <= bus.mem_din;
                        end
                        r_mem_req <= 1'b0;
                        r_state   <= S_RELEASE;
                    end else if (r_count == c_last_count) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (!bus.mem_ack) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_dout = r_mem_dout;
    assign bus.rdata    = r_rdata;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_mem_access_ctrl : directed and randomized bench for mem_access_ctrl  |
// | Revision           : 1.0                                                |
// +-------------------------------------------------------------------------+
module tb_mem_access_ctrl;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: one access = accept, wait up to TIMEOUT cycles for ack,
    // wait for ack to drop, then report.
    typedef enum int { PH_IDLE, PH_WAIT_ACK, PH_WAIT_DROP } phase_t;
    phase_t            m_phase;
    int                m_waited;
    logic              m_req, m_we, m_done, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout, m_rdata;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_waited = 0;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_addr   = '0;
        m_dout   = '0;
        m_rdata  = '0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        case (m_phase)
            PH_IDLE: if (bus.start) begin
                m_addr   = bus.addr_in;
                m_dout   = bus.wdata_in;
                m_we     = bus.write;
                m_err    = 1'b0;
                m_waited = 0;
                m_req    = 1'b1;
                m_phase  = PH_WAIT_ACK;
            end
            PH_WAIT_ACK: begin
                m_waited++;
                if (bus.mem_ack) begin
                    if (!m_we) m_rdata = bus.mem_din;
                    m_req   = 1'b0;
                    m_phase = PH_WAIT_DROP;
                end else if (m_waited == TIMEOUT) begin
                    m_req   = 1'b0;
                    m_err   = 1'b1;
                    m_done  = 1'b1;
                    m_phase = PH_IDLE;
                end
            end
            default: if (!bus.mem_ack) begin
                m_done  = 1'b1;
                m_phase = PH_IDLE;
            end
        endcase
    endtask

    task automatic compare_all();
        check("mem_req",  bus.mem_req,  m_req);
        check("mem_we",   bus.mem_we,   m_we);
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_dout", bus.mem_dout, m_dout);
        check("rdata",    bus.rdata,    m_rdata);
        check("busy",     bus.busy,     m_phase != PH_IDLE);
        check("done",     bus.done,     m_done);
        check("err",      bus.err,      m_err);
    endtask

    task automatic drive(input logic st, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic ack,
                         input logic [DATA_W-1:0] din);
        bus.start    = st;
        bus.write    = wr;
        bus.addr_in  = a;
        bus.wdata_in = wd;
        bus.mem_ack  = ack;
        bus.mem_din  = din;
    endtask

    // Inputs stay stable across the edge; outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_req",  bus.mem_req, 1'b0);
        check("ar_busy", bus.busy,    1'b0);
        check("ar_done", bus.done,    1'b0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive(1'b1, 1'b0, 16'h1234, 32'h5555_5555, 1'b1, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("rst_req_const",  bus.mem_req, 1'b0);
        check("rst_busy_const", bus.busy,    1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h1234, 32'h0, 1'b1, 32'h0);
        step();
        check("idle_after_rst", bus.busy, 1'b0);

        // Load with ack on the second REQ cycle
        drive(1'b1, 1'b0, 16'h01A4, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 16'h01A4, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 16'h01A4, 32'h0, 1'b1, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 16'h01A4, 32'h0, 1'b0, 32'h0);
        step();
        check("load_rdata", bus.rdata,    32'hDEADBEEF);
        check("load_addr",  bus.mem_addr, 16'h01A4);
        check("load_done",  bus.done,     1'b1);
        step();
        check("load_done_1cyc", bus.done, 1'b0);

        // Store leaves rdata untouched
        drive(1'b1, 1'b1, 16'h0010, 32'h12345678, 1'b0, 32'h0);
        step();
        check("store_we",   bus.mem_we,   1'b1);
        check("store_dout", bus.mem_dout, 32'h12345678);
        drive(1'b0, 1'b1, 16'h0010, 32'h0, 1'b1, 32'hCAFE_F00D);
        step();
        drive(1'b0, 1'b1, 16'h0010, 32'h0, 1'b0, 32'h0);
        step();
        check("store_rdata", bus.rdata, 32'hDEADBEEF);
        check("store_done",  bus.done,  1'b1);

        // Timeout: no ack at all
        drive(1'b1, 1'b0, 16'h0200, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 16'h0200, 32'h0, 1'b0, 32'h0);
        repeat (TIMEOUT - 1) begin
            check("to_req_high", bus.mem_req, 1'b1);
            step();
        end
        check("to_req_last", bus.mem_req, 1'b1);
        step();
        check("to_err",  bus.err,  1'b1);
        check("to_done", bus.done, 1'b1);
        check("to_busy", bus.busy, 1'b0);
        drive(1'b1, 1'b0, 16'h0300, 32'h0, 1'b0, 32'h0);
        step();
        check("to_err_clear", bus.err, 1'b0);
        drive(1'b0, 1'b0, 16'h0300, 32'h0, 1'b1, 32'h0BAD_0001);
        step();
        drive(1'b0, 1'b0, 16'h0300, 32'h0, 1'b0, 32'h0);
        step();

        // start held high, addr_in changed while busy
        drive(1'b1, 1'b0, 16'h0ABC, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 16'hFFFF, 32'h0, 1'b1, 32'h1111_2222);
        step();
        check("busy_addr_hold", bus.mem_addr, 16'h0ABC);
        drive(1'b1, 1'b0, 16'hFFFF, 32'h0, 1'b0, 32'h0);
        step();
        check("b2b_done", bus.done, 1'b1);
        step();
        check("b2b_busy",  bus.busy,     1'b1);
        check("b2b_addr",  bus.mem_addr, 16'hFFFF);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 32'h3333_4444);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
        step();

        // Ack on the last permitted REQ cycle
        drive(1'b1, 1'b0, 16'h0042, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 16'h0042, 32'h0, 1'b0, 32'h0);
        repeat (TIMEOUT - 1) step();
        drive(1'b0, 1'b0, 16'h0042, 32'h0, 1'b1, 32'h5A5A_A5A5);
        step();
        check("late_ack_err",  bus.err,  1'b0);
        check("late_ack_busy", bus.busy, 1'b1);
        drive(1'b0, 1'b0, 16'h0042, 32'h0, 1'b0, 32'h0);
        step();

        // Reset during REQ, then during RELEASE
        drive(1'b1, 1'b1, 16'h0077, 32'h7777_7777, 1'b0, 32'h0);
        step();
        async_reset();
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 16'h0078, 32'h0, 1'b1, 32'h8888_8888);
        step();
        step();
        async_reset();
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
        step();
        check("rst_rel_no_done", bus.done, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 30), $urandom_range(0, 1),
                  ADDR_W'($urandom), $urandom,
                  ($urandom_range(0, 99) < 35), $urandom);
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
